decode_stage: RTL and testbench

Registered, parametrised instruction-decode pipeline stage.
- Turns the 4-bit opcode and instruction fields into datapath control signals and an XLEN-wide sign-extended immediate.
- Holds the result in one output slot with valid/ready handshakes on both sides.
- Detects load-use hazards against the instruction in its slot and inserts a bubble.
- Sits between fetch and the register-file/ALU stage of the single-cycle core being converted to a pipeline.

---
 rtl/decode_stage_if.sv | 47 ++++
 rtl/decode_stage.sv | 119 +++++++++++
 tb/tb_decode_stage.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/decode_stage_if.sv
// rtl/decode_stage_if.sv - fetch-side and execute-side handshake bundle for decode_stage
interface decode_stage_if #(
    parameter int XLEN  = 16,
    parameter int RAW   = 3,
    parameter int CNT_W = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       opcode;
    logic [RAW-1:0]   rs1;
    logic [RAW-1:0]   rs2;
    logic [RAW-1:0]   rd;
    logic [6:0]       immediate;
    logic [5:0]       nzimm;
    logic [8:0]       offset;
    logic             out_valid;
    logic             out_ready;
    logic             reg_write;
    logic             reg_dst;
    logic             alu_src1;
    logic             alu_src2;
    logic             mem_write;
    logic             mem_to_reg;
    logic             reg_src;
    logic [3:0]       alu_op;
    logic [XLEN-1:0]  imm;
    logic [RAW-1:0]   rs1_q;
    logic [RAW-1:0]   rs2_q;
    logic [RAW-1:0]   rd_q;
    logic             illegal_q;
    logic             err_sticky;
    logic [CNT_W-1:0] stall_cnt;

    modport master (
        output in_valid, opcode, rs1, rs2, rd, immediate, nzimm, offset, out_ready,
        input  in_ready, out_valid, reg_write, reg_dst, alu_src1, alu_src2, mem_write,
               mem_to_reg, reg_src, alu_op, imm, rs1_q, rs2_q, rd_q, illegal_q,
               err_sticky, stall_cnt
    );

    modport slave (
        input  in_valid, opcode, rs1, rs2, rd, immediate, nzimm, offset, out_ready,
        output in_ready, out_valid, reg_write, reg_dst, alu_src1, alu_src2, mem_write,
               mem_to_reg, reg_src, alu_op, imm, rs1_q, rs2_q, rd_q, illegal_q,
               err_sticky, stall_cnt
    );
endinterface

// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - registered instruction decode stage with load-use bubble insertion
module decode_stage #(
    parameter int XLEN  = 16,
    parameter int RAW   = 3,
    parameter int CNT_W = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    decode_stage_if.slave  bus
);
    logic             reg_write_d, alu_src1_d, alu_src2_d, mem_write_d, mem_to_reg_d, reg_src_d;
    logic             illegal_d, reads_rs2_d, is_lw_d;
    logic [3:0]       alu_op_d;
    logic [XLEN-1:0]  imm_d;
    logic [XLEN-1:0]  imm_i7, imm_n6, imm_o9;

    logic             out_valid_q, reg_write_q, alu_src1_q, alu_src2_q;
    logic             mem_write_q, mem_to_reg_q, reg_src_q, illegal_q, is_lw_q, err_sticky_q;
    logic [3:0]       alu_op_q;
    logic [XLEN-1:0]  imm_q;
    logic [RAW-1:0]   rs1_q, rs2_q, rd_q;
    logic [CNT_W-1:0] stall_cnt_q;

    logic             hazard, in_ready, accept;

    assign imm_i7 = {{(XLEN-7){bus.immediate[6]}}, bus.immediate};
    assign imm_n6 = {{(XLEN-6){bus.nzimm[5]}}, bus.nzimm};
    assign imm_o9 = {{(XLEN-9){bus.offset[8]}}, bus.offset};

    // Tuple order: reg_write, alu_src1, alu_src2, alu_op, mem_write, mem_to_reg, reg_src
    always_comb begin
        {reg_write_d, alu_src1_d, alu_src2_d, alu_op_d, mem_write_d, mem_to_reg_d, reg_src_d} = '0;
        imm_d       = '0;
        illegal_d   = 1'b0;
        reads_rs2_d = 1'b0;
        is_lw_d     = 1'b0;
        case (bus.opcode)
            4'd0:  begin {reg_write_d, alu_src1_d, alu_src2_d, alu_op_d, mem_write_d, mem_to_reg_d, reg_src_d} = 10'b1_0_1_0000_0_1_0; imm_d = imm_i7; is_lw_d = 1'b1; end
            4'd1:  begin {reg_write_d, alu_src1_d, alu_src2_d, alu_op_d, mem_write_d, mem_to_reg_d, reg_src_d} = 10'b0_0_1_0000_1_0_0; imm_d = imm_i7; reads_rs2_d = 1'b1; end
            4'd2:  begin {reg_write_d, alu_src1_d, alu_src2_d, alu_op_d, mem_write_d, mem_to_reg_d, reg_src_d} = 10'b1_0_0_0000_0_0_0; reads_rs2_d = 1'b1; end
            4'd3:  begin {reg_write_d, alu_src1_d, alu_src2_d, alu_op_d, mem_write_d, mem_to_reg_d, reg_src_d} = 10'b1_0_1_0000_0_0_1; imm_d = imm_n6; end
            4'd4:  begin {reg_write_d, alu_src1_d, alu_src2_d, alu_op_d, mem_write_d, mem_to_reg_d, reg_src_d} = 10'b1_0_0_0010_0_0_1; reads_rs2_d = 1'b1; end
            4'd5:  begin {reg_write_d, alu_src1_d, alu_src2_d, alu_op_d, mem_write_d, mem_to_reg_d, reg_src_d} = 10'b1_0_1_0010_0_0_1; imm_d = imm_i7; end
            4'd6:  begin {reg_write_d, alu_src1_d, alu_src2_d, alu_op_d, mem_write_d, mem_to_reg_d, reg_src_d} = 10'b1_0_0_0011_0_0_1; reads_rs2_d = 1'b1; end
            4'd7:  begin {reg_write_d, alu_src1_d, alu_src2_d, alu_op_d, mem_write_d, mem_to_reg_d, reg_src_d} = 10'b1_0_0_1000_0_0_1; reads_rs2_d = 1'b1; end
            4'd8:  begin {reg_write_d, alu_src1_d, alu_src2_d, alu_op_d, mem_write_d, mem_to_reg_d, reg_src_d} = 10'b1_0_1_0100_0_0_1; imm_d = imm_n6; end
            4'd9:  begin {reg_write_d, alu_src1_d, alu_src2_d, alu_op_d, mem_write_d, mem_to_reg_d, reg_src_d} = 10'b1_0_1_0101_0_0_1; imm_d = imm_n6; end
            4'd10: begin {reg_write_d, alu_src1_d, alu_src2_d, alu_op_d, mem_write_d, mem_to_reg_d, reg_src_d} = 10'b0_1_0_0110_0_0_0; imm_d = imm_o9; end
            4'd11: begin {reg_write_d, alu_src1_d, alu_src2_d, alu_op_d, mem_write_d, mem_to_reg_d, reg_src_d} = 10'b0_1_0_0111_0_0_0; imm_d = imm_o9; end
            default: illegal_d = 1'b1;
        endcase
    end

    // Illegal opcodes decode as reading neither register, and is_lw_q stays 0 for them.
    assign hazard   = bus.in_valid && out_valid_q && is_lw_q &&
                      ((!illegal_d && bus.rs1 == rd_q) || (reads_rs2_d && bus.rs2 == rd_q));
    assign in_ready = (!out_valid_q || bus.out_ready) && !hazard;
    assign accept   = bus.in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q  <= 1'b0;
            reg_write_q  <= 1'b0;
            alu_src1_q   <= 1'b0;
            alu_src2_q   <= 1'b0;
            alu_op_q     <= '0;
            mem_write_q  <= 1'b0;
            mem_to_reg_q <= 1'b0;
            reg_src_q    <= 1'b0;
            imm_q        <= '0;
            rs1_q        <= '0;
            rs2_q        <= '0;
            rd_q         <= '0;
            illegal_q    <= 1'b0;
            is_lw_q      <= 1'b0;
            err_sticky_q <= 1'b0;
            stall_cnt_q  <= '0;
        end else begin
            if (accept) begin
                out_valid_q  <= 1'b1;
                reg_write_q  <= reg_write_d;
                alu_src1_q   <= alu_src1_d;
                alu_src2_q   <= alu_src2_d;
                alu_op_q     <= alu_op_d;
                mem_write_q  <= mem_write_d;
                mem_to_reg_q <= mem_to_reg_d;
                reg_src_q    <= reg_src_d;
                imm_q        <= imm_d;
                rs1_q        <= bus.rs1;
                rs2_q        <= bus.rs2;
                rd_q         <= bus.rd;
                illegal_q    <= illegal_d;
                is_lw_q      <= is_lw_d;
                if (illegal_d) err_sticky_q <= 1'b1;
            end else if (bus.out_ready) begin
                out_valid_q <= 1'b0;
            end
            if (hazard && !(&stall_cnt_q)) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
        end
    end

    assign bus.in_ready   = in_ready;
    assign bus.out_valid  = out_valid_q;
    assign bus.reg_write  = reg_write_q;
    assign bus.reg_dst    = reg_write_q;
    assign bus.alu_src1   = alu_src1_q;
    assign bus.alu_src2   = alu_src2_q;
    assign bus.alu_op     = alu_op_q;
    assign bus.mem_write  = mem_write_q;
    assign bus.mem_to_reg = mem_to_reg_q;
    assign bus.reg_src    = reg_src_q;
    assign bus.imm        = imm_q;
    assign bus.rs1_q      = rs1_q;
    assign bus.rs2_q      = rs2_q;
    assign bus.rd_q       = rd_q;
    assign bus.illegal_q  = illegal_q;
    assign bus.err_sticky = err_sticky_q;
    assign bus.stall_cnt  = stall_cnt_q;
endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - directed checks of decode_stage; outputs sampled on the falling edge
module tb_decode_stage;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    decode_stage_if #(.XLEN(16), .RAW(3), .CNT_W(16)) bus1 ();
    decode_stage_if #(.XLEN(16), .RAW(3), .CNT_W(2))  bus2 ();

    decode_stage #(.XLEN(16), .RAW(3), .CNT_W(16)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
    decode_stage #(.XLEN(16), .RAW(3), .CNT_W(2))  dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

    int vectors = 0;
    int miscompares = 0;

    // {reg_write, reg_dst, alu_src1, alu_src2, alu_op, mem_write, mem_to_reg, reg_src}
    localparam logic [10:0] C_LW   = 11'b1101_0000_010;
    localparam logic [10:0] C_ADD  = 11'b1100_0000_000;
    localparam logic [10:0] C_ADDI = 11'b1101_0000_001;
    localparam logic [10:0] C_OR   = 11'b1100_0011_001;
    localparam logic [10:0] C_XOR  = 11'b1100_1000_001;

    logic [10:0] exp_ctrl [0:11] = '{
        11'b1101_0000_010, 11'b0001_0000_100, 11'b1100_0000_000, 11'b1101_0000_001,
        11'b1100_0010_001, 11'b1101_0010_001, 11'b1100_0011_001, 11'b1100_1000_001,
        11'b1101_0100_001, 11'b1101_0101_001, 11'b0010_0110_000, 11'b0010_0111_000};
    logic [15:0] exp_imm [0:11] = '{
        16'hFFC0, 16'hFFC0, 16'h0000, 16'hFFFF, 16'h0000, 16'h0015,
        16'h0000, 16'h0000, 16'hFFFF, 16'hFFE0, 16'h00FF, 16'hFF00};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [10:0] ctl1();
        return {bus1.reg_write, bus1.reg_dst, bus1.alu_src1, bus1.alu_src2, bus1.alu_op,
                bus1.mem_write, bus1.mem_to_reg, bus1.reg_src};
    endfunction

    function automatic logic [10:0] ctl2();
        return {bus2.reg_write, bus2.reg_dst, bus2.alu_src1, bus2.alu_src2, bus2.alu_op,
                bus2.mem_write, bus2.mem_to_reg, bus2.reg_src};
    endfunction

    task automatic drive1(input logic v, input logic [3:0] op, input logic [2:0] r1,
                          input logic [2:0] r2, input logic [2:0] d, input logic [6:0] i7,
                          input logic [5:0] n6, input logic [8:0] o9);
        bus1.in_valid = v; bus1.opcode = op; bus1.rs1 = r1; bus1.rs2 = r2; bus1.rd = d;
        bus1.immediate = i7; bus1.nzimm = n6; bus1.offset = o9;
    endtask

    task automatic drive2(input logic v, input logic [3:0] op, input logic [2:0] r1,
                          input logic [2:0] r2, input logic [2:0] d);
        bus2.in_valid = v; bus2.opcode = op; bus2.rs1 = r1; bus2.rs2 = r2; bus2.rd = d;
        bus2.immediate = '0; bus2.nzimm = '0; bus2.offset = '0;
    endtask

    initial begin
        drive1(1'b0, 4'd0, 3'd0, 3'd0, 3'd0, 7'h0, 6'h0, 9'h0);
        drive2(1'b0, 4'd0, 3'd0, 3'd0, 3'd0);
        bus1.out_ready = 1'b1;
        bus2.out_ready = 1'b1;

        repeat (2) @(negedge clk);
        chk("rst_out_valid", 32'(bus1.out_valid), 32'd0);
        chk("rst_in_ready", 32'(bus1.in_ready), 32'd1);
        chk("rst_ctrl", 32'(ctl1()), 32'd0);
        chk("rst_stall_err", 32'({bus1.stall_cnt, bus1.err_sticky, bus1.illegal_q}), 32'd0);
        rst_n = 1'b1;

        // Reset while the slot holds a valid add
        drive1(1'b1, 4'd2, 3'd1, 3'd2, 3'd4, 7'h0, 6'h0, 9'h0);
        @(negedge clk);
        chk("pre_rst_valid", 32'(bus1.out_valid), 32'd1);
        chk("pre_rst_ctrl", 32'(ctl1()), 32'(C_ADD));
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(bus1.out_valid), 32'd0);
        chk("mid_rst_ctrl", 32'(ctl1()), 32'd0);
        chk("mid_rst_rd_q", 32'(bus1.rd_q), 32'd0);
        chk("mid_rst_in_ready", 32'(bus1.in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        drive1(1'b1, 4'd7, 3'd2, 3'd3, 3'd6, 7'h0, 6'h0, 9'h0);
        @(negedge clk);
        chk("post_rst_valid", 32'(bus1.out_valid), 32'd1);
        chk("post_rst_ctrl", 32'(ctl1()), 32'(C_XOR));
        chk("post_rst_regs", 32'({bus1.rs2_q, bus1.rd_q}), 32'({3'd3, 3'd6}));

        // Back-to-back sweep of all legal opcodes
        for (int k = 0; k < 12; k++) begin
            drive1(1'b1, 4'(k), 3'(k + 1), 3'(k + 2), 3'(k),
                   (k == 5) ? 7'h15 : 7'h40, (k == 9) ? 6'h20 : 6'h3F,
                   (k == 11) ? 9'h100 : 9'h0FF);
            #1 chk($sformatf("sweep%0d_in_ready", k), 32'(bus1.in_ready), 32'd1);
            @(negedge clk);
            chk($sformatf("sweep%0d_valid", k), 32'(bus1.out_valid), 32'd1);
            chk($sformatf("sweep%0d_ctrl", k), 32'(ctl1()), 32'(exp_ctrl[k]));
            chk($sformatf("sweep%0d_imm", k), 32'(bus1.imm), 32'(exp_imm[k]));
            chk($sformatf("sweep%0d_rd_q", k), 32'(bus1.rd_q), 32'(k % 8));
        end
        bus1.in_valid = 1'b0;
        @(negedge clk);
        chk("sweep_drain", 32'(bus1.out_valid), 32'd0);

        // Load-use: lw rd=3 followed by add reading r3 through rs2
        drive1(1'b1, 4'd0, 3'd5, 3'd6, 3'd3, 7'h01, 6'h0, 9'h0);
        @(negedge clk);
        chk("lu_lw_ctrl", 32'(ctl1()), 32'(C_LW));
        drive1(1'b1, 4'd2, 3'd1, 3'd3, 3'd4, 7'h0, 6'h0, 9'h0);
        #1 chk("lu_in_ready", 32'(bus1.in_ready), 32'd0);
        @(negedge clk);
        chk("lu_bubble", 32'(bus1.out_valid), 32'd0);
        chk("lu_stall_cnt", 32'(bus1.stall_cnt), 32'd1);
        @(negedge clk);
        chk("lu_add_valid", 32'(bus1.out_valid), 32'd1);
        chk("lu_add_ctrl", 32'(ctl1()), 32'(C_ADD));
        chk("lu_add_regs", 32'({bus1.rs1_q, bus1.rs2_q, bus1.rd_q}), 32'({3'd1, 3'd3, 3'd4}));
        drive1(1'b1, 4'd0, 3'd5, 3'd6, 3'd3, 7'h01, 6'h0, 9'h0);
        @(negedge clk);
        drive1(1'b1, 4'd3, 3'd1, 3'd3, 3'd2, 7'h0, 6'h01, 9'h0);
        #1 chk("nolu_in_ready", 32'(bus1.in_ready), 32'd1);
        @(negedge clk);
        chk("nolu_addi_ctrl", 32'(ctl1()), 32'(C_ADDI));
        chk("nolu_addi_imm", 32'(bus1.imm), 32'h0001);
        chk("nolu_stall_cnt", 32'(bus1.stall_cnt), 32'd1);
        bus1.in_valid = 1'b0;

        // Backpressure: or held in the slot for 4 cycles while upstream fields change
        @(negedge clk);
        drive1(1'b1, 4'd6, 3'd1, 3'd2, 3'd5, 7'h0, 6'h0, 9'h0);
        @(negedge clk);
        bus1.out_ready = 1'b0;
        for (int c = 0; c < 4; c++) begin
            drive1(1'b1, (c % 2 == 0) ? 4'd7 : 4'd4, 3'd2, 3'd3, 3'd6, 7'h0, 6'h0, 9'h0);
            #1 chk($sformatf("bp%0d_in_ready", c), 32'(bus1.in_ready), 32'd0);
            @(negedge clk);
            chk($sformatf("bp%0d_hold", c),
                32'({bus1.out_valid, ctl1(), bus1.rd_q}), 32'({1'b1, C_OR, 3'd5}));
        end
        bus1.out_ready = 1'b1;
        drive1(1'b1, 4'd7, 3'd2, 3'd3, 3'd6, 7'h0, 6'h0, 9'h0);
        #1 chk("bp_resume_in_ready", 32'(bus1.in_ready), 32'd1);
        @(negedge clk);
        chk("bp_resume_slot", 32'({bus1.out_valid, ctl1(), bus1.rd_q}), 32'({1'b1, C_XOR, 3'd6}));
        bus1.in_valid = 1'b0;
        @(negedge clk);
        chk("bp_no_dup", 32'(bus1.out_valid), 32'd0);

        // Illegal opcode 13 with rd=1; a following reader of r1 must not stall
        drive1(1'b1, 4'd13, 3'd0, 3'd0, 3'd1, 7'h7F, 6'h3F, 9'h1FF);
        @(negedge clk);
        chk("ill_flags", 32'({bus1.out_valid, bus1.illegal_q, bus1.err_sticky}), 32'b111);
        chk("ill_ctrl_imm", 32'({ctl1(), bus1.imm}), 32'd0);
        drive1(1'b1, 4'd2, 3'd1, 3'd1, 3'd7, 7'h0, 6'h0, 9'h0);
        #1 chk("ill_no_hazard", 32'(bus1.in_ready), 32'd1);
        @(negedge clk);
        chk("ill_after_legal", 32'({bus1.illegal_q, bus1.err_sticky, ctl1()}), 32'({2'b01, C_ADD}));
        bus1.in_valid = 1'b0;
        @(negedge clk);
        chk("ill_sticky_idle", 32'(bus1.err_sticky), 32'd1);

        // Saturation with CNT_W=2, and load-use while downstream is stalled
        bus2.out_ready = 1'b0;
        drive2(1'b1, 4'd0, 3'd0, 3'd0, 3'd3);
        @(negedge clk);
        drive2(1'b1, 4'd2, 3'd3, 3'd0, 3'd1);
        #1 chk("sat_in_ready", 32'(bus2.in_ready), 32'd0);
        repeat (2) @(negedge clk);
        chk("sat_cnt2", 32'(bus2.stall_cnt), 32'd2);
        repeat (3) @(negedge clk);
        chk("sat_cnt3", 32'(bus2.stall_cnt), 32'd3);
        chk("sat_lw_held", 32'({bus2.out_valid, ctl2()}), 32'({1'b1, C_LW}));
        bus2.out_ready = 1'b1;
        @(negedge clk);
        chk("sat_bubble", 32'(bus2.out_valid), 32'd0);
        chk("sat_in_ready_after", 32'(bus2.in_ready), 32'd1);
        @(negedge clk);
        chk("sat_add_out", 32'({bus2.out_valid, ctl2(), bus2.stall_cnt}), 32'({1'b1, C_ADD, 2'd3}));
        bus2.in_valid = 1'b0;
        rst_n = 1'b0;
        #1 chk("sat_rst_cnt", 32'(bus2.stall_cnt), 32'd0);
        chk("final_rst_err", 32'(bus1.err_sticky), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
